// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and memory-port bundle for mem_arbiter.
// slave is the arbiter's view; master drives requests and memory responses.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              r0_enable_i;
    logic [ADDR_W-1:0] r0_addr_i;
    logic              r0_ack_o;
    logic [LINE_W-1:0] r0_data_o;
    logic              r1_enable_i;
    logic              r1_write_i;
    logic [ADDR_W-1:0] r1_addr_i;
    logic [LINE_W-1:0] r1_data_i;
    logic              r1_ack_o;
    logic [LINE_W-1:0] r1_data_o;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic [LINE_W-1:0] mem_data_i;
    logic              mem_ack_i;
    logic              err_o;
    modport slave (
        input  r0_enable_i, r0_addr_i, r1_enable_i, r1_write_i, r1_addr_i, r1_data_i,
               mem_data_i, mem_ack_i,
        output r0_ack_o, r0_data_o, r1_ack_o, r1_data_o, mem_enable_o, mem_write_o,
               mem_addr_o, mem_data_o, err_o
    );
    modport master (
        output r0_enable_i, r0_addr_i, r1_enable_i, r1_write_i, r1_addr_i, r1_data_i,
               mem_data_i, mem_ack_i,
        input  r0_ack_o, r0_data_o, r1_ack_o, r1_data_o, mem_enable_o, mem_write_o,
               mem_addr_o, mem_data_o, err_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin share of one line-wide memory port between an
// icache (read only) and a dcache (read/write-back), with sticky timeout flag.
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int LINE_W      = 256,
    parameter int TIMEOUT_CYC = 64
) (
    input logic      clk_i,
    input logic      rst_i,
    mem_arbiter_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t            state_q, state_d;
    logic              gnt_q, gnt_d, rr_last_q, rr_last_d, win;
    logic [1:0]        mask_q, mask_d, elig;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic              mem_en_q, mem_en_d, mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_data_q, mem_data_d, data0_q, data0_d, data1_q, data1_d;
    logic              ack0_q, ack0_d, ack1_q, ack1_d, err_q, err_d;
    always_comb begin
        elig       = {bus.r1_enable_i, bus.r0_enable_i} & ~mask_q;
        win        = (elig == 2'b11) ? ~rr_last_q : elig[1];
        cnt_inc    = (cnt_q == CW'(TIMEOUT_CYC)) ? cnt_q : cnt_q + 1'b1;
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_last_d  = rr_last_q;
        mask_d     = mask_q;
        cnt_d      = cnt_q;
        mem_en_d   = mem_en_q;
        mem_wr_d   = mem_wr_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        data0_d    = data0_q;
        data1_d    = data1_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                mask_d = '0;
                if (|elig) begin
                    state_d    = BUSY;
                    gnt_d      = win;
                    rr_last_d  = win;
                    mem_en_d   = 1'b1;
                    mem_wr_d   = win & bus.r1_write_i;
                    mem_addr_d = win ? bus.r1_addr_i : bus.r0_addr_i;
                    mem_data_d = win ? bus.r1_data_i : mem_data_q;
                end
            end
            BUSY: begin
                cnt_d = cnt_inc;
                err_d = err_q | (cnt_inc == CW'(TIMEOUT_CYC));
                if (bus.mem_ack_i) begin
                    state_d  = RESP;
                    cnt_d    = '0;
                    mem_en_d = 1'b0;
                    mem_wr_d = 1'b0;
                    ack0_d   = ~gnt_q;
                    ack1_d   = gnt_q;
                    // write completions leave the requester's read data untouched
                    data0_d  = (!mem_wr_q && !gnt_q) ? bus.mem_data_i : data0_q;
                    data1_d  = (!mem_wr_q && gnt_q) ? bus.mem_data_i : data1_q;
                end
            end
            RESP: begin
                state_d = IDLE;
                mask_d  = gnt_q ? 2'b10 : 2'b01;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            rr_last_q  <= 1'b1;
            mask_q     <= '0;
            cnt_q      <= '0;
            mem_en_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            data0_q    <= '0;
            data1_q    <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_last_q  <= rr_last_d;
            mask_q     <= mask_d;
            cnt_q      <= cnt_d;
            mem_en_q   <= mem_en_d;
            mem_wr_q   <= mem_wr_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            data0_q    <= data0_d;
            data1_q    <= data1_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            err_q      <= err_d;
        end
    end
    assign bus.mem_enable_o = mem_en_q;
    assign bus.mem_write_o  = mem_wr_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_data_o   = mem_data_q;
    assign bus.r0_ack_o     = ack0_q;
    assign bus.r0_data_o    = data0_q;
    assign bus.r1_ack_o     = ack1_q;
    assign bus.r1_data_o    = data1_q;
    assign bus.err_o        = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with an ack scoreboard; a negedge monitor
// pops the expected port/data whenever an r*_ack_o pulse appears.
module tb_mem_arbiter;
    localparam logic [255:0] DA  = {8{32'hAAAA_AAAA}};
    localparam logic [255:0] D12 = {8{32'h1234_5678}};
    localparam logic [255:0] DB  = {8{32'hDEAD_BEEF}};
    localparam logic [255:0] D1  = {8{32'h1111_0001}};
    localparam logic [255:0] D2  = {8{32'h2222_0002}};
    localparam logic [255:0] D3  = {8{32'h3333_0003}};
    localparam logic [255:0] D4  = {8{32'h4444_0004}};
    localparam logic [255:0] D5  = {8{32'h5555_0005}};
    localparam logic [255:0] D6  = {8{32'h6666_0006}};
    localparam logic [255:0] D7  = {8{32'h7777_0007}};
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    mem_arbiter_if #(.ADDR_W(32), .LINE_W(256)) bus ();
    mem_arbiter #(.ADDR_W(32), .LINE_W(256), .TIMEOUT_CYC(64)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus)
    );
    typedef struct {bit port; logic [255:0] data;} exp_t;
    exp_t sb[$];
    exp_t mon_e;
    logic mon_port;
    logic [255:0] mon_data;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic serve(input int lat, input logic [31:0] addr, input logic wr,
                         input logic [255:0] wdata, input logic [255:0] rdata);
        int n = 0;
        while (bus.mem_enable_o !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        chk1("grant_wait", bus.mem_enable_o, 1'b1);
        chk("mem_addr", 256'(bus.mem_addr_o), 256'(addr));
        chk1("mem_write", bus.mem_write_o, wr);
        if (wr) chk("mem_data", bus.mem_data_o, wdata);
        tick(lat);
        chk("mem_addr_held", 256'(bus.mem_addr_o), 256'(addr));
        chk1("mem_write_held", bus.mem_write_o, wr);
        if (wr) chk("mem_data_held", bus.mem_data_o, wdata);
        bus.mem_ack_i  = 1'b1;
        bus.mem_data_i = rdata;
        tick(1);
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = '0;
        chk1("mem_enable_drop", bus.mem_enable_o, 1'b0);
        chk1("mem_write_drop", bus.mem_write_o, 1'b0);
    endtask

    always @(negedge clk) begin
        if (!rst && (bus.r0_ack_o || bus.r1_ack_o)) begin
            checks++;
            if (bus.r0_ack_o && bus.r1_ack_o) begin
                errors++;
                $display("FAIL both_acks: got r0_ack=1 r1_ack=1 expected one");
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: got r0_ack=%b r1_ack=%b expected none", bus.r0_ack_o, bus.r1_ack_o);
            end else begin
                mon_e    = sb.pop_front();
                mon_port = bus.r1_ack_o;
                mon_data = mon_port ? bus.r1_data_o : bus.r0_data_o;
                if (mon_port !== mon_e.port || mon_data !== mon_e.data) begin
                    errors++;
                    $display("FAIL ack_resp: got port %0d data %h expected port %0d data %h", mon_port, mon_data, mon_e.port, mon_e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.r0_enable_i = 1'b0; bus.r0_addr_i = '0;
        bus.r1_enable_i = 1'b0; bus.r1_write_i = 1'b0; bus.r1_addr_i = '0; bus.r1_data_i = '0;
        bus.mem_ack_i = 1'b0; bus.mem_data_i = '0;
        #1;
        chk1("rst_mem_enable", bus.mem_enable_o, 1'b0);
        chk1("rst_mem_write", bus.mem_write_o, 1'b0);
        chk("rst_mem_addr", 256'(bus.mem_addr_o), '0);
        chk("rst_mem_data", bus.mem_data_o, '0);
        chk1("rst_r0_ack", bus.r0_ack_o, 1'b0);
        chk1("rst_r1_ack", bus.r1_ack_o, 1'b0);
        chk("rst_r0_data", bus.r0_data_o, '0);
        chk("rst_r1_data", bus.r1_data_o, '0);
        chk1("rst_err", bus.err_o, 1'b0);
        tick(2);
        rst = 1'b0;
        // r0 read, one-cycle grant latency
        bus.r0_addr_i = 32'h40; bus.r0_enable_i = 1'b1;
        sb.push_back('{1'b0, DA});
        tick(1);
        chk1("t1_latency", bus.mem_enable_o, 1'b1);
        serve(10, 32'h40, 1'b0, '0, DA);
        chk1("t1_r0_ack", bus.r0_ack_o, 1'b1);
        chk1("t1_r1_ack", bus.r1_ack_o, 1'b0);
        chk("t1_r0_data", bus.r0_data_o, DA);
        bus.r0_enable_i = 1'b0;
        tick(1);
        chk1("t1_r0_ack_pulse", bus.r0_ack_o, 1'b0);
        // r1 write-back
        bus.r1_addr_i = 32'h400; bus.r1_write_i = 1'b1; bus.r1_data_i = D12; bus.r1_enable_i = 1'b1;
        sb.push_back('{1'b1, '0});
        serve(4, 32'h400, 1'b1, D12, DB);
        chk1("t2_r1_ack", bus.r1_ack_o, 1'b1);
        chk("t2_r1_data", bus.r1_data_o, '0);
        bus.r1_enable_i = 1'b0; bus.r1_write_i = 1'b0;
        tick(1);
        chk1("t2_r1_ack_pulse", bus.r1_ack_o, 1'b0);
        tick(1);
        // simultaneous requests held for three transactions
        bus.r0_addr_i = 32'h100; bus.r1_addr_i = 32'h200;
        bus.r0_enable_i = 1'b1; bus.r1_enable_i = 1'b1;
        sb.push_back('{1'b0, D1}); sb.push_back('{1'b1, D2}); sb.push_back('{1'b0, D3});
        serve(3, 32'h100, 1'b0, '0, D1);
        serve(5, 32'h200, 1'b0, '0, D2);
        serve(2, 32'h100, 1'b0, '0, D3);
        bus.r0_enable_i = 1'b0; bus.r1_enable_i = 1'b0;
        tick(2);
        chk1("t3_idle", bus.mem_enable_o, 1'b0);
        // r1 arrives while r0 is busy; grant three edges after mem_ack
        bus.r0_addr_i = 32'h80; bus.r0_enable_i = 1'b1;
        sb.push_back('{1'b0, D4});
        tick(1);
        chk("t4_r0_addr", 256'(bus.mem_addr_o), 256'(32'h80));
        bus.r1_addr_i = 32'h800; bus.r1_enable_i = 1'b1;
        sb.push_back('{1'b1, D5});
        tick(3);
        bus.mem_ack_i = 1'b1; bus.mem_data_i = D4;
        tick(1);
        bus.mem_ack_i = 1'b0; bus.mem_data_i = '0; bus.r0_enable_i = 1'b0;
        chk1("t4_edge1_en", bus.mem_enable_o, 1'b0);
        tick(1);
        chk1("t4_edge2_en", bus.mem_enable_o, 1'b0);
        chk("t4_edge2_addr", 256'(bus.mem_addr_o), 256'(32'h80));
        tick(1);
        chk1("t4_edge3_en", bus.mem_enable_o, 1'b1);
        chk("t4_edge3_addr", 256'(bus.mem_addr_o), 256'(32'h800));
        serve(2, 32'h800, 1'b0, '0, D5);
        bus.r1_enable_i = 1'b0;
        tick(2);
        // memory withholds ack past the timeout
        bus.r0_addr_i = 32'hC0; bus.r0_enable_i = 1'b1;
        sb.push_back('{1'b0, D6});
        tick(1);
        chk1("t5_grant", bus.mem_enable_o, 1'b1);
        tick(63);
        chk1("t5_err_before", bus.err_o, 1'b0);
        tick(1);
        chk1("t5_err_at", bus.err_o, 1'b1);
        tick(5);
        bus.mem_ack_i = 1'b1; bus.mem_data_i = D6;
        tick(1);
        bus.mem_ack_i = 1'b0; bus.mem_data_i = '0; bus.r0_enable_i = 1'b0;
        tick(3);
        chk1("t5_err_sticky", bus.err_o, 1'b1);
        chk("t5_r0_data", bus.r0_data_o, D6);
        // reset in the middle of a wait
        bus.r0_addr_i = 32'h140; bus.r0_enable_i = 1'b1;
        tick(1);
        chk1("t6_grant", bus.mem_enable_o, 1'b1);
        tick(4);
        rst = 1'b1;
        #1;
        chk1("t6_rst_en", bus.mem_enable_o, 1'b0);
        chk1("t6_rst_err", bus.err_o, 1'b0);
        chk1("t6_rst_r0_ack", bus.r0_ack_o, 1'b0);
        chk1("t6_rst_r1_ack", bus.r1_ack_o, 1'b0);
        bus.r0_enable_i = 1'b0;
        tick(1);
        rst = 1'b0;
        bus.mem_ack_i = 1'b1; bus.mem_data_i = DB;
        tick(1);
        bus.mem_ack_i = 1'b0; bus.mem_data_i = '0;
        chk1("t6_stray_r0", bus.r0_ack_o, 1'b0);
        chk1("t6_stray_r1", bus.r1_ack_o, 1'b0);
        tick(1);
        chk1("t6_stray_r0_late", bus.r0_ack_o, 1'b0);
        chk("t6_r0_data_cleared", bus.r0_data_o, '0);
        bus.r0_addr_i = 32'h180; bus.r0_enable_i = 1'b1;
        sb.push_back('{1'b0, D7});
        serve(6, 32'h180, 1'b0, '0, D7);
        chk1("t6_fresh_ack", bus.r0_ack_o, 1'b1);
        bus.r0_enable_i = 1'b0;
        tick(3);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_empty: got %0d pending acks expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single off-chip data memory port (256-bit line interface, enable/write/ack handshake) between two line-fill requesters.
- Requester 0 is the instruction-cache controller (read only). Requester 1 is the dcache_controller (read and write-back).
- Sits between the cache controllers and the CPU top-level mem_* ports.
- Round-robin grant, registered memory-side outputs, registered ack/data return, sticky timeout flag.

Parameters:
- ADDR_W, 32, address width.
- LINE_W, 256, cache line / memory data width.
- TIMEOUT_CYC, 64, wait cycles after which err_o latches (must be ≥2).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- r0_enable_i  in  1  requester 0 request (held until r0_ack_o).
- r0_addr_i  in  ADDR_W  requester 0 line address.
- r0_ack_o  out  1  requester 0 completion pulse.
- r0_data_o  out  LINE_W  read data for requester 0.
- r1_enable_i  in  1  requester 1 request (held until r1_ack_o).
- r1_write_i  in  1  requester 1: 1 = write, 0 = read.
- r1_addr_i  in  ADDR_W  requester 1 line address.
- r1_data_i  in  LINE_W  requester 1 write data.
- r1_ack_o  out  1  requester 1 completion pulse.
- r1_data_o  out  LINE_W  read data for requester 1.
- mem_enable_o  out  1  memory request.
- mem_write_o  out  1  memory write.
- mem_addr_o  out  ADDR_W  memory address.
- mem_data_o  out  LINE_W  memory write data.
- mem_data_i  in  LINE_W  memory read data.
- mem_ack_i  in  1  memory completion pulse.
- err_o  out  1  sticky timeout flag.

Behaviour:
- Clock clk_i. Reset rst_i is asynchronous and active-high.
- Reset values:
  - FSM state = IDLE.
  - All outputs 0: mem_*, r*_ack_o, r*_data_o, err_o.
  - rr_last = 1, so requester 0 wins the first tie.
  - wait counter = 0; mask bits = 0.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Eligible requesters are those with r*_enable_i high and mask bit clear.
  - If none are eligible, stay in IDLE.
  - If one is eligible, grant it.
  - If both are eligible, grant the one ≠ rr_last.
  - On grant (same edge):
    - Latch grant id.
    - Set rr_last = grant id.
    - Register the requester's addr into mem_addr_o.
    - Register r1_data_i into mem_data_o and r1_write_i into mem_write_o for requester 1. For requester 0, mem_write_o = 0 and mem_data_o is unchanged.
    - Set mem_enable_o = 1 and go to BUSY.
  - Request-to-mem_enable_o latency: 1 cycle.
- BUSY:
  - mem_addr_o, mem_write_o and mem_data_o stay constant.
  - Wait counter increments each cycle; it saturates at TIMEOUT_CYC.
  - When the counter reaches TIMEOUT_CYC, err_o is set to 1 and held until reset. The arbiter keeps waiting; no abort.
  - On mem_ack_i = 1:
    - mem_enable_o and mem_write_o go to 0.
    - mem_data_i is captured into the granted requester's r*_data_o.
    - The granted r*_ack_o goes to 1 and the FSM goes to RESP.
    - Wait counter clears.
  - mem_ack_i outside BUSY is ignored.
- RESP:
  - r*_ack_o is high for exactly this one cycle.
  - At the end of RESP, go to IDLE and set the served requester's mask bit.
  - The mask bit clears after one IDLE cycle. This covers the requester's registered enable drop.
  - r*_data_o holds its value until the next read completion for that requester.
- Minimum turnaround: ack from memory → next grant = 3 edges (RESP, masked IDLE, grant).
- Simultaneous events:
  - Both requests rise in the same cycle: round-robin decides.
  - A request arriving during BUSY/RESP waits; it is never dropped.
- Requester dropping enable before ack: protocol violation; the transaction still completes and is acked.
- Reset mid-BUSY: all state clears immediately. mem_enable_o drops asynchronously; no ack is issued.
- mem_write_o is never 1 for requester 0.

Test Plan:
- Reset, then r0 read at 0x0000_0040; memory acks after 10 cycles with data 0xAAAA…(256b) → mem_enable_o=1 one cycle after the request, mem_write_o=0, mem_addr_o=0x40; r0_ack_o one-cycle pulse the cycle after mem_ack_i; r0_data_o=0xAAAA…; r1_ack_o stays 0.
- r1 write at 0x0000_0400 with data 0x1234…5678 → mem_write_o=1, mem_data_o=0x1234…5678 held through BUSY; r1_ack_o single pulse; r1_data_o unchanged.
- r0 and r1 raise enable in the same cycle, both held across 3 transactions → grants r0, r1, r0 (rr alternation); each ack goes to the correct port; no cycle has both acks high.
- r1 request arrives while r0 is BUSY → r1 is granted exactly 3 edges after r0's mem_ack_i; mem_addr_o switches only at the grant.
- Memory withholds ack with TIMEOUT_CYC=64 → err_o rises after 64 BUSY cycles and stays 1 after a later ack and completion, until rst_i.
- rst_i asserted mid-BUSY (cycle 5 of the wait) → mem_enable_o, err_o and both acks are 0 immediately; a stray mem_ack_i afterwards produces no r*_ack_o; a fresh r0 request then proceeds normally.
